// File: rtl/vga_rect_pkg.sv
// Shared types and defaults for the rectangle-table writer.
// Holds the FSM state encoding and the FIFO entry layout {clear, addr, data}.
package vga_rect_pkg;

    localparam int RECTBITS_DEF  = 6;
    localparam int DATABITS_DEF  = 32;
    localparam int DEPTHBITS_DEF = 3;

    localparam int ENTRY_BITS_DEF = 1 + RECTBITS_DEF + 1 + DATABITS_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int entry_bits(input int rectbits, input int databits);
        return 1 + rectbits + 1 + databits;
    endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Show-ahead synchronous FIFO for queued rectangle commands.
// Pushes while full and pops while empty are ignored.
module vga_cmd_fifo #(
    parameter int WIDTH     = 40,
    parameter int DEPTHBITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTHBITS;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTHBITS-1:0] wr_ptr;
    logic [DEPTHBITS-1:0] rd_ptr;
    logic [DEPTHBITS:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy never exceeds DEPTH, so its top bit alone flags full.
    assign full  = count[DEPTHBITS];
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_rect_writer.sv
// Drains queued rectangle updates into the VGA rectangle table during vblank only,
// including a clear-all command that zeroes every slot in order.
//
// state | meaning
// IDLE  | apply head write entries while vblank is high; start a clear when head is clear-all
// CLEAR | write zero to slot ccnt each vblank cycle; pop the clear entry after the last slot
module vga_rect_writer
    import vga_rect_pkg::*;
#(
    parameter int RECTBITS  = RECTBITS_DEF,
    parameter int DATABITS  = DATABITS_DEF,
    parameter int DEPTHBITS = DEPTHBITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd__valid,
    output logic                cmd__ready,
    input  logic                cmd__clear,
    input  logic [RECTBITS:0]   cmd__addr,
    input  logic [DATABITS-1:0] cmd__data,
    input  logic                vblank,
    output logic [RECTBITS:0]   vg__addr,
    output logic [DATABITS-1:0] vg__data,
    output logic                vg__write,
    output logic                busy
);

    localparam int ENTRY_W = entry_bits(RECTBITS, DATABITS);

    state_t              state, state_n;
    logic [RECTBITS:0]   ccnt, ccnt_n;
    logic [ENTRY_W-1:0]  head;
    logic                full, empty, push, pop;
    logic                head_clear;
    logic [RECTBITS:0]   head_addr;
    logic [DATABITS-1:0] head_data;
    logic                wr_en;
    logic [RECTBITS:0]   wr_addr;
    logic [DATABITS-1:0] wr_data;

    assign cmd__ready = !full;
    assign push       = cmd__valid && !full;
    assign busy       = !empty || (state == CLEAR);

    assign head_clear = head[ENTRY_W-1];
    assign head_addr  = head[DATABITS +: RECTBITS+1];
    assign head_data  = head[DATABITS-1:0];

    vga_cmd_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTHBITS (DEPTHBITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cmd__clear, cmd__addr, cmd__data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ccnt  <= '0;
        end else begin
            state <= state_n;
            ccnt  <= ccnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ccnt_n  = ccnt;
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = ccnt;
        wr_data = '0;
        case (state)
            IDLE: begin
                if (!empty && vblank) begin
                    if (head_clear) begin
                        state_n = CLEAR;
                        ccnt_n  = '0;
                    end else begin
                        pop     = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = head_addr;
                        wr_data = head_data;
                    end
                end
            end
            CLEAR: begin
                if (vblank) begin
                    wr_en = 1'b1;
                    // Last slot: retire the clear entry rather than wrap into a second pass.
                    if (ccnt == {(RECTBITS+1){1'b1}}) begin
                        pop     = 1'b1;
                        state_n = IDLE;
                        ccnt_n  = '0;
                    end else begin
                        ccnt_n = ccnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vg__write <= 1'b0;
            vg__addr  <= '0;
            vg__data  <= '0;
        end else begin
            vg__write <= wr_en;
            if (wr_en) begin
                vg__addr <= wr_addr;
                vg__data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_writer.sv
// Directed bench for vga_rect_writer: reset, vblank gating, full FIFO,
// clear ordering with a vblank gap, reset mid-clear and streaming push/pop.
module tb_vga_rect_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd__valid;
    logic        cmd__ready;
    logic        cmd__clear;
    logic [6:0]  cmd__addr;
    logic [31:0] cmd__data;
    logic        vblank;
    logic [6:0]  vg__addr;
    logic [31:0] vg__data;
    logic        vg__write;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    logic [38:0] wq[$];
    int          wstamp[$];

    vga_rect_writer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd__valid (cmd__valid),
        .cmd__ready (cmd__ready),
        .cmd__clear (cmd__clear),
        .cmd__addr  (cmd__addr),
        .cmd__data  (cmd__data),
        .vblank     (vblank),
        .vg__addr   (vg__addr),
        .vg__data   (vg__data),
        .vg__write  (vg__write),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (vg__write) begin
            wq.push_back({vg__addr, vg__data});
            wstamp.push_back(cyc_cnt);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic c, input logic [6:0] a, input logic [31:0] d);
        cmd__valid = 1'b1;
        cmd__clear = c;
        cmd__addr  = a;
        cmd__data  = d;
        for (int i = 0; i < 300; i++) begin
            if (cmd__ready) break;
            cyc();
        end
        if (!cmd__ready) check("push_timeout", 0, 1);
        cyc();
        cmd__valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            cyc();
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int n;
        int bad;

        rst = 1'b1;
        cmd__valid = 1'b1;
        cmd__clear = 1'b0;
        cmd__addr  = 7'd9;
        cmd__data  = 32'h5555_AAAA;
        vblank     = 1'b1;

        // Reset with commands driven
        repeat (3) cyc();
        check("rst_write", vg__write, 0);
        check("rst_addr", vg__addr, 0);
        check("rst_data", vg__data, 0);
        check("rst_ready", cmd__ready, 1);
        check("rst_busy", busy, 0);
        cmd__valid = 1'b0;
        rst = 1'b0;
        wq.delete(); wstamp.delete();
        repeat (5) cyc();
        check("post_rst_nowrite", wq.size(), 0);

        // Blanking gate
        vblank = 1'b0;
        push(1'b0, 7'd5, 32'hDEAD_BEEF);
        repeat (20) cyc();
        check("gate_nowrite", wq.size(), 0);
        check("gate_busy", busy, 1);
        vblank = 1'b1;
        cyc();
        check("gate_write", vg__write, 1);
        check("gate_addr", vg__addr, 5);
        check("gate_data", vg__data, 32'hDEAD_BEEF);
        check("gate_busy_drop", busy, 0);
        cyc();
        check("gate_strobe_single", vg__write, 0);
        check("gate_count", wq.size(), 1);

        // Full FIFO
        vblank = 1'b0;
        wq.delete(); wstamp.delete();
        for (int i = 0; i < 8; i++) push(1'b0, 7'(i), 32'h100 + 32'(i));
        check("full_ready_low", cmd__ready, 0);
        cmd__valid = 1'b1;
        cmd__clear = 1'b0;
        cmd__addr  = 7'd8;
        cmd__data  = 32'h108;
        repeat (3) cyc();
        check("full_held", cmd__ready, 0);
        check("full_nowrite", wq.size(), 0);
        vblank = 1'b1;
        cyc();
        check("full_ready_back", cmd__ready, 1);
        check("full_first_addr", vg__addr, 0);
        cyc();
        cmd__valid = 1'b0;
        repeat (12) cyc();
        check("full_count", wq.size(), 9);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 9; i++) begin
            if (wq[i] !== {7'(i), 32'h100 + 32'(i)}) bad++;
            if (i > 0 && wstamp[i] != wstamp[i-1] + 1) bad++;
        end
        check("full_order", bad, 0);
        check("full_idle", busy, 0);

        // Clear ordering with a vblank gap
        vblank = 1'b0;
        wq.delete(); wstamp.delete();
        push(1'b1, 7'd0, 32'hFFFF_FFFF);
        push(1'b0, 7'd3, 32'h12);
        vblank = 1'b1;
        repeat (50) cyc();
        vblank = 1'b0;
        cyc();
        n = wq.size();
        repeat (3) cyc();
        check("clr_gap_nowrite", wq.size(), n);
        check("clr_gap_strobe", vg__write, 0);
        vblank = 1'b1;
        wait_idle("clr_timeout");
        repeat (2) cyc();
        check("clr_count", wq.size(), 129);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 128; i++)
            if (wq[i] !== {7'(i), 32'h0}) bad++;
        check("clr_sequence", bad, 0);
        if (wq.size() == 129) check("clr_tail", wq[128], {7'd3, 32'h12});
        check("clr_idle", busy, 0);

        // Reset mid-clear
        wq.delete(); wstamp.delete();
        push(1'b1, 7'd0, 32'h0);
        push(1'b0, 7'd9, 32'h7);
        for (int i = 0; i < 300; i++) begin
            if (wq.size() >= 40) break;
            cyc();
        end
        check("midclr_reached", wq.size() >= 40, 1);
        rst = 1'b1;
        #1;
        check("midclr_write", vg__write, 0);
        check("midclr_busy", busy, 0);
        check("midclr_ready", cmd__ready, 1);
        cyc();
        n = wq.size();
        rst = 1'b0;
        repeat (20) cyc();
        check("midclr_nowrite", wq.size(), n);
        check("midclr_empty", busy, 0);

        // Streaming push/pop with vblank high
        vblank = 1'b1;
        wq.delete(); wstamp.delete();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            cmd__valid = 1'b1;
            cmd__clear = 1'b0;
            cmd__addr  = 7'(i + 10);
            cmd__data  = 32'hA000 + 32'(i);
            if (!cmd__ready) bad++;
            cyc();
        end
        cmd__valid = 1'b0;
        check("stream_ready", bad, 0);
        repeat (4) cyc();
        check("stream_count", wq.size(), 30);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 30; i++) begin
            if (wq[i] !== {7'(i + 10), 32'hA000 + 32'(i)}) bad++;
            if (i > 0 && wstamp[i] != wstamp[i-1] + 1) bad++;
        end
        check("stream_order", bad, 0);
        check("stream_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_rect_writer.md
# vga_rect_writer

Producer side of the rectangle-table write port (`vg__addr` / `vg__data` / `vg__write`) that feeds the VGA pipeline's rectangle memory. It accepts rectangle updates from the game/host logic over a valid/ready command stream and buffers them in a small FIFO. It drains them into the rectangle table only while the display is in vertical blanking, so a frame never shows a half-updated scene. It also executes a "clear all" command that zeroes every rectangle slot.

## Interface
- `RECTBITS`, 6: the rectangle address is `RECTBITS+1` bits wide, giving 2^(RECTBITS+1) slots (128 by default).
- `DATABITS`, 32: width of one rectangle descriptor word.
- `DEPTHBITS`, 3: FIFO depth is 2^DEPTHBITS entries (8 by default).

Ports:
- `clk`  in  1  single clock, same domain as the VGA pipeline.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd__valid`  in  1  command present.
- `cmd__ready`  out  1  command accepted on any cycle where both valid and ready are high.
- `cmd__clear`  in  1  when high, the command is clear-all; `cmd__addr` and `cmd__data` are ignored.
- `cmd__addr`  in  RECTBITS+1  target slot.
- `cmd__data`  in  DATABITS  descriptor word.
- `vblank`  in  1  high during vertical blanking; synchronous to `clk`.
- `vg__addr`  out  RECTBITS+1  table write address; registered.
- `vg__data`  out  DATABITS  table write data; registered.
- `vg__write`  out  1  single-cycle write strobe; registered.
- `busy`  out  1  high when the FIFO is non-empty or a clear is in progress.

## Operation
- FIFO entry is `{clear, addr, data}`.
- `cmd__ready = !full`. Ready is low when full, so a push never coincides with overflow.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- States:
  - IDLE: FIFO empty or `vblank` low; no write issued.
  - WRITE: combinational decision, not a held state. If the FIFO is non-empty, the head entry has clear=0, and `vblank`=1, then pop and register a write of `{addr, data}`.
  - CLEAR: entered when the head entry has clear=1 and `vblank`=1. The clear counter `ccnt` starts at 0.
- Behaviour in CLEAR:
  - Each cycle with `vblank`=1, register a write of addr=`ccnt`, data=0, then increment `ccnt`.
  - Cycles with `vblank`=0 issue no write and hold `ccnt`.
  - After the write at `ccnt` = 2^(RECTBITS+1)-1, pop the clear entry and return to IDLE.
  - `ccnt` must not wrap into a second pass.
- Entries are applied strictly in FIFO order. A write queued behind a clear lands after the clear, so it survives.
- When no write is issued, `vg__write`=0. `vg__addr` and `vg__data` hold their last values.
- `busy` = FIFO non-empty OR state==CLEAR.

## Timing
- Reset values: `vg__write`=0, `vg__addr`=0, `vg__data`=0, `cmd__ready`=1, `busy`=0. The FIFO is emptied, state goes to IDLE, and `ccnt`=0.
- Latency: a write decision in cycle t, made with `vblank`(t)=1, appears on `vg__*` in cycle t+1. The `vblank` source must deassert one cycle before active video.
- The minimum latency from command accept to table write is 2 cycles: accept at t, head visible at t+1, write visible at t+2.
- Throughput is one table write per cycle while `vblank` is high.
- Reset mid-clear aborts the clear immediately. No further writes occur and the queued entries are discarded.
- If `vblank` falls mid-drain, writes stop at the next cycle boundary and resume on the next blanking interval.

## Structure
- Package `vga_rect_pkg` holds:
  - the state enum {IDLE, CLEAR};
  - the FIFO entry width constant `1+RECTBITS+1+DATABITS`;
  - the default parameter values.
- Sub-module `vga_cmd_fifo`: a synchronous FIFO with push/pop, full/empty, and a show-ahead head output, sized by `DEPTHBITS`.
- The FSM, clear counter and output registers live in the top module.

## Test plan
- Reset: hold `rst`=1 while driving commands. Required: `vg__write`=0, `vg__addr`=0, `cmd__ready`=1, `busy`=0, and no write for 5 cycles after release.
- Blanking gate: with `vblank`=0, push addr=5 data=0xDEADBEEF. Required: no write for 20 cycles. Then raise `vblank` at t; exactly one write addr=5 data=0xDEADBEEF at t+1; `busy` drops at t+1.
- Full: with `vblank`=0, push 9 commands back-to-back with addr 0..8. Required: `cmd__ready` goes low after the 8th accept and the 9th is held. Then raise `vblank`: writes to addr 0..7 on consecutive cycles, and `cmd__ready` returns high one cycle after the first pop.
- Clear ordering: push clear, then addr=3 data=0x12. Toggle `vblank` low for 4 cycles in the middle of the clear. Required: 128 zero writes to addr 0..127 with no gaps or repeats, then the addr=3 write; `busy`=0 afterwards.
- Reset mid-clear: assert `rst` while `ccnt`=40. Required: `vg__write`=0 that cycle onward, FIFO empty, and no writes after release.
- Concurrent push/pop: with `vblank`=1, push one command per cycle for 30 cycles. Required: one write per cycle in order, `cmd__ready` stays 1, and occupancy never exceeds 1.
